// File: rtl/isp_pkg.sv
// Shared ISP pipeline constants: channel tags, filter modes and
// the channel sequencing helper.
package isp_pkg;

  localparam logic [2:0] RED   = 3'd0;
  localparam logic [2:0] GREEN = 3'd1;
  localparam logic [2:0] BLUE  = 3'd2;
  localparam logic [2:0] VOID  = 3'd3;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_SMOOTH = 2'd1;
  localparam logic [1:0] MODE_MEDIAN = 2'd2;
  localparam logic [1:0] MODE_ADAPT  = 2'd3;

  function automatic logic [2:0] next_ch(
    input logic [2:0] ch,
    input logic [2:0] last_ch
  );
    return (ch == last_ch) ? RED : ch + 3'd1;
  endfunction

endpackage

// File: rtl/denoise_kern3.sv
// Combinational 3-tap filter kernel on window (a, b, c), b centred.
// Bypass, 1-2-1 smoothing, median, or threshold-gated median.
module denoise_kern3
  import isp_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] THRESH = DATA_W'(32)
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] y
);

  localparam int SW = DATA_W + 2;

  logic [SW-1:0]     w_sum;
  logic [DATA_W-1:0] w_smooth;
  logic [DATA_W-1:0] w_lo_ab;
  logic [DATA_W-1:0] w_hi_ab;
  logic [DATA_W-1:0] w_mid;
  logic [DATA_W-1:0] w_med;
  logic [DATA_W-1:0] w_diff;

  always_comb begin
    // Max sum 4*(2^W-1)+2 fits in W+2 bits; >>2 stays <= 2^W-1
    w_sum = SW'(a) + SW'({b, 1'b0}) + SW'(c) + SW'(2);
    w_smooth = w_sum[SW-1:2];
    w_lo_ab = (a < b) ? a : b;
    w_hi_ab = (a < b) ? b : a;
    w_mid = (w_hi_ab < c) ? w_hi_ab : c;
    w_med = (w_lo_ab > w_mid) ? w_lo_ab : w_mid;
    w_diff = (b > w_med) ? (b - w_med) : (w_med - b);
    y = b;
    unique case (mode)
      MODE_BYPASS: y = b;
      MODE_SMOOTH: y = w_smooth;
      MODE_MEDIAN: y = w_med;
      MODE_ADAPT:  y = (w_diff > THRESH) ? w_med : b;
    endcase
  end

endmodule

// File: rtl/denoise_line3.sv
// Line-based 3-tap denoise on a channel-interleaved pixel stream.
// Drops the first and last pixel of each line; 1-cycle latency.
module denoise_line3
  import isp_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                NUM_CH = 3,
  parameter logic [DATA_W-1:0] THRESH = DATA_W'(32)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              valid_in,
  input  logic [2:0]        color_in,
  input  logic              last_col_in,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] pixel_out,
  output logic              valid_out,
  output logic [2:0]        color_out,
  output logic              last_col_out,
  output logic              err_seq
);

  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  logic [DATA_W-1:0] r_h1 [NUM_CH];
  logic [DATA_W-1:0] r_h2 [NUM_CH];
  logic [1:0]        r_cnt;
  logic [2:0]        r_exp;
  logic [1:0]        r_mode;

  logic              w_ok;
  logic              w_bad;
  logic              w_eol;
  logic              w_emit;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_y;

  always_comb begin
    w_ok = valid_in && (color_in == r_exp)
        && (color_in <= LAST_CH);
    w_bad = valid_in && !w_ok;
    w_eol = w_ok && last_col_in
         && (color_in == LAST_CH);
    w_emit = w_ok && (r_cnt == 2'd2);
    w_a = '0;
    w_b = '0;
    if (w_ok) begin
      w_a = r_h2[color_in];
      w_b = r_h1[color_in];
    end
  end

  denoise_kern3 #(
    .DATA_W(DATA_W),
    .THRESH(THRESH)
  ) u_kern (
    .a   (w_a),
    .b   (w_b),
    .c   (pixel_in),
    .mode(r_mode),
    .y   (w_y)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_out    <= '0;
      valid_out    <= 1'b0;
      color_out    <= '0;
      last_col_out <= 1'b0;
      err_seq      <= 1'b0;
      r_cnt        <= '0;
      r_exp        <= RED;
      r_mode       <= MODE_BYPASS;
      for (int i = 0; i < NUM_CH; i++) begin
        r_h1[i] <= '0;
        r_h2[i] <= '0;
      end
    end else begin
      valid_out    <= w_emit;
      last_col_out <= w_emit && last_col_in;
      if (w_emit) begin
        pixel_out <= w_y;
        color_out <= color_in;
      end
      if (w_bad) err_seq <= 1'b1;
      if (w_ok) begin
        r_exp <= next_ch(r_exp, LAST_CH);
        // Mode is frozen for the line at its very first beat
        if (r_cnt == 2'd0 && color_in == RED)
          r_mode <= mode;
        if (w_eol) begin
          r_cnt <= '0;
          for (int i = 0; i < NUM_CH; i++) begin
            r_h1[i] <= '0;
            r_h2[i] <= '0;
          end
        end else begin
          r_h2[color_in] <= r_h1[color_in];
          r_h1[color_in] <= pixel_in;
          if (color_in == LAST_CH && r_cnt != 2'd2)
            r_cnt <= r_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_denoise_line3.sv
// Self-checking bench for denoise_line3: line vector table,
// output scoreboard, protocol/reset and mode-latch sequences.
module tb_denoise_line3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pixel_in;
  logic       valid_in;
  logic [2:0] color_in;
  logic       last_col_in;
  logic [1:0] mode;
  logic [7:0] pixel_out;
  logic       valid_out;
  logic [2:0] color_out;
  logic       last_col_out;
  logic       err_seq;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [7:0] px;
    logic [2:0] col;
    logic       lst;
  } exp_t;

  typedef struct packed {
    logic [1:0]      md;
    logic [2:0]      n;
    logic [1:0]      gap;
    logic [4:0][7:0] r;
    logic [2:0][7:0] e;
  } vec_t;

  exp_t q[$];
  vec_t vt[10];

  denoise_line3 #(
    .DATA_W(8),
    .NUM_CH(3),
    .THRESH(8'd32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_in    (pixel_in),
    .valid_in    (valid_in),
    .color_in    (color_in),
    .last_col_in (last_col_in),
    .mode        (mode),
    .pixel_out   (pixel_out),
    .valid_out   (valid_out),
    .color_out   (color_out),
    .last_col_out(last_col_out),
    .err_seq     (err_seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic check_out();
    exp_t it;
    if (valid_out) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL spurious_out: got px=%0d col=%0d want none",
                 pixel_out, color_out);
      end else begin
        it = q.pop_front();
        if (pixel_out !== it.px || color_out !== it.col
            || last_col_out !== it.lst) begin
          bad++;
          $display("FAIL out_beat: got px=%0d col=%0d last=%0d want px=%0d col=%0d last=%0d",
                   pixel_out, color_out, last_col_out,
                   it.px, it.col, it.lst);
        end
      end
    end else if (q.size() != 0) begin
      total++;
      bad++;
      it = q.pop_front();
      $display("FAIL missing_out: got none want px=%0d col=%0d",
               it.px, it.col);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic beat(input logic [2:0] col, input logic [7:0] px,
                      input logic lst, input logic emit,
                      input logic [7:0] epx);
    pixel_in = px;
    color_in = col;
    last_col_in = lst;
    valid_in = 1'b1;
    if (emit) q.push_back('{px: epx, col: col, lst: lst});
    step();
    valid_in = 1'b0;
    last_col_in = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] r, input logic lst,
                          input logic emit, input logic [7:0] er);
    beat(3'd0, r, lst, emit, er);
    beat(3'd1, 8'd5, lst, emit, 8'd5);
    beat(3'd2, 8'd0, lst, emit, 8'd0);
  endtask

  task automatic send_line(input vec_t v);
    mode = v.md;
    for (int k = 0; k < int'(v.n); k++) begin
      send_pix(v.r[k], k == int'(v.n) - 1, k >= 2,
               (k >= 2) ? v.e[k-2] : 8'd0);
      for (int g = 0; g < int'(v.gap); g++) step();
    end
  endtask

  function automatic vec_t mk(input logic [1:0] md,
                              input int n, input int gap,
                              input logic [39:0] r,
                              input logic [23:0] e);
    vec_t v;
    v.md = md;
    v.n = 3'(n);
    v.gap = 2'(gap);
    v.r = r;
    v.e = e;
    return v;
  endfunction

  initial begin
    logic [7:0] mr[4];
    rst = 1'b0;
    pixel_in = '0;
    valid_in = 1'b0;
    color_in = '0;
    last_col_in = 1'b0;
    mode = 2'd0;

    // Pixel order in packed fields: rightmost = pixel 0
    vt[0] = mk(2'd2, 5, 0, {8'd13, 8'd14, 8'd12, 8'd200, 8'd10},
               {8'd13, 8'd14, 8'd12});
    vt[1] = mk(2'd1, 5, 0, {8'd13, 8'd14, 8'd12, 8'd200, 8'd10},
               {8'd13, 8'd60, 8'd106});
    vt[2] = mk(2'd3, 5, 0, {8'd13, 8'd14, 8'd12, 8'd200, 8'd10},
               {8'd14, 8'd12, 8'd12});
    vt[3] = mk(2'd0, 4, 2, {8'd0, 8'd4, 8'd3, 8'd2, 8'd1},
               {8'd0, 8'd3, 8'd2});
    vt[4] = mk(2'd0, 4, 2, {8'd0, 8'd8, 8'd7, 8'd6, 8'd5},
               {8'd0, 8'd7, 8'd6});
    vt[5] = mk(2'd2, 2, 0, {8'd0, 8'd0, 8'd0, 8'd60, 8'd50},
               {8'd0, 8'd0, 8'd0});
    vt[6] = mk(2'd1, 3, 0, {8'd0, 8'd0, 8'd255, 8'd255, 8'd255},
               {8'd0, 8'd0, 8'd255});
    vt[7] = mk(2'd3, 3, 1, {8'd0, 8'd0, 8'd0, 8'd32, 8'd0},
               {8'd0, 8'd0, 8'd32});
    vt[8] = mk(2'd3, 3, 0, {8'd0, 8'd0, 8'd0, 8'd33, 8'd0},
               {8'd0, 8'd0, 8'd0});
    vt[9] = mk(2'd2, 1, 0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd7},
               {8'd0, 8'd0, 8'd0});

    step();
    step();
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_color_out", color_out, 0);
    chk("rst_last_col_out", last_col_out, 0);
    chk("rst_err_seq", err_seq, 0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) send_line(vt[i]);
    chk("err_after_lines", err_seq, 0);

    // Mode change mid-line applies from the next line
    mr[0] = 8'd1; mr[1] = 8'd9; mr[2] = 8'd2; mr[3] = 8'd8;
    mode = 2'd0;
    send_pix(mr[0], 1'b0, 1'b0, 8'd0);
    send_pix(mr[1], 1'b0, 1'b0, 8'd0);
    mode = 2'd2;
    send_pix(mr[2], 1'b0, 1'b1, 8'd9);
    send_pix(mr[3], 1'b1, 1'b1, 8'd2);
    send_pix(mr[0], 1'b0, 1'b0, 8'd0);
    send_pix(mr[1], 1'b0, 1'b0, 8'd0);
    send_pix(mr[2], 1'b0, 1'b1, 8'd2);
    send_pix(mr[3], 1'b1, 1'b1, 8'd8);

    // Protocol errors, then mid-line reset
    mode = 2'd0;
    beat(3'd0, 8'd5, 1'b0, 1'b0, 8'd0);
    beat(3'd1, 8'd6, 1'b0, 1'b0, 8'd0);
    beat(3'd2, 8'd7, 1'b0, 1'b0, 8'd0);
    beat(3'd0, 8'd8, 1'b0, 1'b0, 8'd0);
    beat(3'd1, 8'd9, 1'b0, 1'b0, 8'd0);
    beat(3'd2, 8'd10, 1'b0, 1'b0, 8'd0);
    beat(3'd0, 8'd11, 1'b0, 1'b1, 8'd8);
    beat(3'd1, 8'd12, 1'b0, 1'b1, 8'd9);
    beat(3'd2, 8'd13, 1'b0, 1'b1, 8'd10);
    beat(3'd0, 8'd20, 1'b0, 1'b1, 8'd11);
    chk("err_before_void", err_seq, 0);
    beat(3'd3, 8'd99, 1'b0, 1'b0, 8'd0);
    chk("err_after_void", err_seq, 1);
    beat(3'd2, 8'd77, 1'b0, 1'b0, 8'd0);
    chk("err_sticky", err_seq, 1);
    chk("hold_pixel_out", pixel_out, 11);
    rst = 1'b0;
    step();
    chk("mid_rst_pixel_out", pixel_out, 0);
    chk("mid_rst_valid_out", valid_out, 0);
    chk("mid_rst_color_out", color_out, 0);
    chk("mid_rst_last_col", last_col_out, 0);
    chk("mid_rst_err_seq", err_seq, 0);
    rst = 1'b1;

    send_line(vt[0]);
    chk("err_after_recovery", err_seq, 0);

    step();
    step();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/denoise_line3.md
Name: denoise_line3

Overview:
- Parametrised successor to the fixed 8-bit RGB denoise stage in the ISP pixel pipeline.
- Accepts a channel-interleaved pixel stream: one channel sample per beat, tagged by color index, with a last-column flag.
- Applies a per-channel 3-tap horizontal filter: bypass, 1-2-1 smoothing, median, or threshold-gated adaptive median.
- Emits the same interleaved format, dropping the first and last pixel of each line, so each line loses 2 pixels.

Parameters:
- DATA_W, 8: bits per channel sample.
- NUM_CH, 3: channels per pixel, 1..7; color tag values 0..NUM_CH-1 are legal.
- THRESH, 32: adaptive-mode impulse threshold, DATA_W bits, unsigned.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- pixel_in  in  DATA_W  channel sample
- valid_in  in  1  beat qualifier
- color_in  in  3  channel index of this beat
- last_col_in  in  1  beat belongs to the last pixel of the line
- mode  in  2  0 bypass, 1 smooth, 2 median, 3 adaptive
- pixel_out  out  DATA_W  filtered sample
- valid_out  out  1  output beat qualifier
- color_out  out  3  channel index of output beat
- last_col_out  out  1  output beat belongs to the last output pixel of the line
- err_seq  out  1  sticky protocol error flag

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-low. While rst=0 at a rising edge, all state clears.
- Reset values: pixel_out=0, valid_out=0, color_out=0, last_col_out=0, err_seq=0, pixel counter=0, expected channel=0, all window registers=0.
- Beat acceptance:
  - A beat is accepted only on a rising edge with valid_in=1; there is no backpressure.
  - Idle cycles between beats are allowed, and the window state is held across them.
- Channel order:
  - Beats must arrive in order 0,1,..,NUM_CH-1 per pixel.
  - If an accepted color_in differs from the expected channel, or color_in >= NUM_CH, then err_seq is set (sticky until reset), the beat is dropped, and no output is produced for it.
- Window:
  - Each channel keeps a 2-deep history, prev2 and prev1.
  - Accepting channel c of pixel k (k >= 2) completes window (k-2, k-1, k) = (a, b, c), centred on pixel k-1.
  - History then shifts.
- Latency:
  - The output beat is registered and appears 1 cycle after the accepting edge, carrying color_out = c.
  - For pixel counter < 2 in the line, only the history is loaded and valid_out stays 0.
- Filter, with b as the centre sample:
  - Mode 0: b.
  - Mode 1: (a + 2b + c + 2) >> 2, computed in DATA_W+2 bits; the result never exceeds 2^DATA_W - 1.
  - Mode 2: median(a, b, c).
  - Mode 3: median if |b - median| > THRESH, else b; the comparison is strict and unsigned.
- Mode latch: mode is sampled on the accepted channel-0 beat of pixel 0 of each line and held for the whole line. Mid-line changes take effect on the next line.
- Line end:
  - On an accepted beat with last_col_in=1 and channel NUM_CH-1, that beat is processed normally.
  - The pixel counter and history then clear, so no window spans two lines.
  - last_col_out=1 on every output beat generated from that final input pixel.
- Short lines: a line of fewer than 3 pixels produces no output and clears state at its last beat.
- Pixel counter saturates at 2; no line-length limit.
- last_col_in is evaluated per beat. If it is 1 on a non-final channel, that beat is treated as normal, and the line ends only on channel NUM_CH-1.

Decomposition:
- Shared package isp_pkg holds:
  - color index constants RED=0, GREEN=1, BLUE=2, VOID=3;
  - mode constants MODE_BYPASS, MODE_SMOOTH, MODE_MEDIAN, MODE_ADAPT.
- One natural sub-module, denoise_kern3: purely combinational (a, b, c, mode, THRESH) -> result, parametrised on DATA_W.
- Top level holds the channel sequencer, the per-channel history array (NUM_CH x 2 x DATA_W), the line counter and the output register.

Test Plan:
- Median mode, NUM_CH=3, one 5-pixel line, R channel = 10,200,12,14,13, G/B = 0 -> exactly 9 output beats; R outputs 12,14,13; last_col_out=1 only on the final R/G/B triple; each output 1 cycle after its input beat.
- Smooth mode, same R line -> R outputs 106, 60, 13.
- Adaptive mode, THRESH=32, same R line -> R outputs 12, 12, 14.
- Bypass, two back-to-back 4-pixel lines, R = 1,2,3,4 then 5,6,7,8, plus valid_in gaps of 2 cycles -> R outputs 2,3 then 6,7; no cross-line window; gaps do not change values.
- Protocol: send color_in=VOID with valid_in=1, then skip G (R then B) -> err_seq=1 from the next cycle, offending beats produce no output; rst=0 mid-line -> all outputs 0 next cycle and err_seq cleared.
- Mode change mid-line from 0 to 2 -> current line stays bypass; next line is median-filtered.
